// File: rtl/ifq_pkg.sv
// Shared types for the instruction fetch queue: FSM state encoding, the queued
// {instr, pc} entry and the instruction size in bytes.
package ifq_pkg;

  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_STALL = 2'd2
  } ifq_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ifq_entry_t;

endpackage

// File: rtl/ifq_if.sv
// Fetch-queue bus: redirect input, imem request/response and the decode handshake.
// Decode side: an entry transfers on a rising edge where out_valid && out_ready.
interface ifq_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;
  logic [1:0]  dbg_state;
  logic [7:0]  dbg_count;

  modport master (
    input  redirect_valid, redirect_pc, imem_rvalid, imem_rdata, out_ready,
    output imem_req, imem_addr, out_valid, out_instr, out_pc, dbg_state, dbg_count
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_rvalid, imem_rdata, out_ready,
    input  imem_req, imem_addr, out_valid, out_instr, out_pc, dbg_state, dbg_count
  );
endinterface

// File: rtl/ifq_fifo.sv
// Power-of-two FIFO of fetch entries; flush has priority over push and pop.
module ifq_fifo
  import ifq_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  ifq_entry_t               wdata_i,
  output ifq_entry_t               rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  ifq_entry_t    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !flush_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !flush_i && !empty_o;

  // Pointers are AW bits wide, so the increment wraps modulo DEPTH for free.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Sequential instruction fetcher with credit-based issue, epoch-tagged responses and
// redirect flush. Define IFQ_BYPASS_EN to forward a response straight to decode when empty.
module instr_fetch_queue
  import ifq_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic   clk,
  input logic   rst,
  ifq_if.master bus
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [1:0] ST_BOOT  = S_BOOT;
  localparam logic [1:0] ST_FETCH = S_FETCH;
  localparam logic [1:0] ST_STALL = S_STALL;

  logic [1:0]  state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        inflight_q, inflight_d;
  logic        epoch_q, epoch_d;
  logic        pend_epoch_q, pend_epoch_d;

  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;
  ifq_entry_t    fifo_head, head_sel, resp_entry;
  logic          issue, accept, push, pop, has_credit, redirect;
  logic [CW-1:0] credit;
  logic          out_valid;

  assign redirect   = bus.redirect_valid;
  // A request in flight already owns a slot, so it is charged against the credit.
  assign credit     = CW'(DEPTH) - fifo_count - CW'(inflight_q);
  assign has_credit = (credit != '0) && !fifo_full;
  assign accept     = bus.imem_rvalid && inflight_q && (pend_epoch_q == epoch_q);
  assign resp_entry = '{instr: bus.imem_rdata, pc: pend_pc_q};

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      ST_BOOT:  state_d = ST_FETCH;
      ST_FETCH: begin
        if (has_credit) issue = 1'b1;
        else            state_d = ST_STALL;
      end
      ST_STALL: if (has_credit) state_d = ST_FETCH;
      default:  state_d = ST_BOOT;
    endcase
    if (redirect) begin
      issue   = 1'b0;
      state_d = ST_FETCH;
    end
  end

`ifdef IFQ_BYPASS_EN
  logic bypass;
  assign bypass    = accept && fifo_empty && !redirect;
  assign push      = accept && !redirect && !(bypass && bus.out_ready);
  assign out_valid = !fifo_empty || bypass;
  assign head_sel  = bypass ? resp_entry : fifo_head;
`else
  assign push      = accept && !redirect;
  assign out_valid = !fifo_empty;
  assign head_sel  = fifo_head;
`endif

  assign pop = !fifo_empty && bus.out_ready && !redirect;

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    pend_pc_d    = pend_pc_q;
    inflight_d   = inflight_q;
    epoch_d      = epoch_q;
    pend_epoch_d = pend_epoch_q;
    if (redirect) begin
      fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
      inflight_d = 1'b0;
      epoch_d    = ~epoch_q;
    end else if (issue) begin
      fetch_pc_d   = fetch_pc_q + 32'(INSTR_BYTES);
      pend_pc_d    = fetch_pc_q;
      inflight_d   = 1'b1;
      pend_epoch_d = epoch_q;
    end else if (bus.imem_rvalid) begin
      inflight_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_BOOT;
      fetch_pc_q   <= RESET_PC;
      pend_pc_q    <= '0;
      inflight_q   <= 1'b0;
      epoch_q      <= 1'b0;
      pend_epoch_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      pend_pc_q    <= pend_pc_d;
      inflight_q   <= inflight_d;
      epoch_q      <= epoch_d;
      pend_epoch_q <= pend_epoch_d;
    end
  end

  ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (resp_entry),
    .rdata_o (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.imem_req  = issue;
  assign bus.imem_addr = fetch_pc_q;
  assign bus.out_valid = out_valid;
  assign bus.out_instr = out_valid ? head_sel.instr : 32'h0;
  assign bus.out_pc    = out_valid ? head_sel.pc    : 32'h0;
  assign bus.dbg_state = state_q;
  assign bus.dbg_count = 8'(fifo_count);

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: two instances (RESET_PC 0 and FFFF_FFF8)
// behind a 1-cycle memory that returns addr ^ A5A5_0000.
module tb_instr_fetch_queue;

  localparam logic [31:0] XOR_PAT = 32'hA5A5_0000;
  localparam logic [31:0] RPC_B   = 32'hFFFF_FFF8;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  ifq_if ifa ();
  ifq_if ifb ();

  instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  instr_fetch_queue #(.DEPTH(4), .RESET_PC(RPC_B)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // instruction memory models, fixed 1-cycle latency
  always @(posedge clk) begin
    ifa.imem_rvalid <= ifa.imem_req;
    ifa.imem_rdata  <= ifa.imem_addr ^ XOR_PAT;
    ifb.imem_rvalid <= ifb.imem_req;
    ifb.imem_rdata  <= ifb.imem_addr ^ XOR_PAT;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // advance one edge, then let outputs settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, ".req"},   32'(ifa.imem_req),  32'h0);
    chk({tag, ".valid"}, 32'(ifa.out_valid), 32'h0);
    chk({tag, ".addr"},  ifa.imem_addr,      32'h0);
    chk({tag, ".instr"}, ifa.out_instr,      32'h0);
    chk({tag, ".pc"},    ifa.out_pc,         32'h0);
    chk({tag, ".count"}, 32'(ifa.dbg_count), 32'h0);
    chk({tag, ".state"}, 32'(ifa.dbg_state), 32'h0);
  endtask

  initial begin
    logic [31:0] pc_b;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    ifa.redirect_valid = 1'b0;
    ifa.redirect_pc    = 32'h0;
    ifa.out_ready      = 1'b1;
    ifb.redirect_valid = 1'b0;
    ifb.redirect_pc    = 32'h0;
    ifb.out_ready      = 1'b1;

    // reset values
    tick();
    tick();
    chk_reset_a("rst");
    chk("rst.b_addr",  ifb.imem_addr,      RPC_B);
    chk("rst.b_valid", 32'(ifb.out_valid), 32'h0);

    // streaming with out_ready=1
    rst = 1'b0;
    #1;
    chk("boot.req", 32'(ifa.imem_req), 32'h0);
    tick();
    chk("s.req1",    32'(ifa.imem_req), 32'h1);
    chk("s.addr0",   ifa.imem_addr,     32'h0);
    chk("s.b_addr0", ifb.imem_addr,     32'hFFFF_FFF8);
    tick();
    chk("s.addr4",   ifa.imem_addr,      32'h4);
    chk("s.valid0",  32'(ifa.out_valid), 32'h0);
    chk("s.b_addr1", ifb.imem_addr,      32'hFFFF_FFFC);
    tick();
    chk("s.valid1",  32'(ifa.out_valid), 32'h1);
    chk("s.pc0",     ifa.out_pc,         32'h0);
    chk("s.instr0",  ifa.out_instr,      32'hA5A5_0000);
    chk("s.b_addr2", ifb.imem_addr,      32'h0);
    chk("s.b_pc0",   ifb.out_pc,         32'hFFFF_FFF8);
    for (int k = 1; k <= 5; k++) begin
      tick();
      pc_b = RPC_B + 32'(4 * k);
      chk("s.pc",     ifa.out_pc,         32'(4 * k));
      chk("s.instr",  ifa.out_instr,      32'(4 * k) ^ XOR_PAT);
      chk("s.addr",   ifa.imem_addr,      32'(4 * (k + 2)));
      chk("s.count",  32'(ifa.dbg_count), 32'h1);
      chk("s.b_pc",   ifb.out_pc,         pc_b);
      chk("s.b_inst", ifb.out_instr,      pc_b ^ XOR_PAT);
    end

    // decode stalled: exactly DEPTH requests, then drain in order
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ifa.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("st.req",  32'(ifa.imem_req), 32'h1);
      chk("st.addr", ifa.imem_addr,     32'(4 * k));
    end
    tick();
    chk("st.noreq5", 32'(ifa.imem_req), 32'h0);
    tick();
    chk("st.noreq6", 32'(ifa.imem_req),  32'h0);
    chk("st.state",  32'(ifa.dbg_state), 32'h2);
    chk("st.count6", 32'(ifa.dbg_count), 32'h4);
    tick();
    chk("st.noreq7", 32'(ifa.imem_req),  32'h0);
    chk("st.count7", 32'(ifa.dbg_count), 32'h4);
    chk("st.pc0",    ifa.out_pc,         32'h0);
    ifa.out_ready = 1'b1;
    tick();
    chk("dr.pc4",    ifa.out_pc,         32'h4);
    chk("dr.count3", 32'(ifa.dbg_count), 32'h3);
    chk("dr.noreq",  32'(ifa.imem_req),  32'h0);
    tick();
    chk("dr.pc8",    ifa.out_pc,         32'h8);
    chk("dr.req",    32'(ifa.imem_req),  32'h1);
    chk("dr.addr10", ifa.imem_addr,      32'h10);
    chk("dr.count2", 32'(ifa.dbg_count), 32'h2);
    tick();
    chk("dr.pcC",    ifa.out_pc,         32'hC);
    chk("dr.count1", 32'(ifa.dbg_count), 32'h1);
    tick();
    chk("dr.pc10",   ifa.out_pc,         32'h10);
    chk("dr.ins10",  ifa.out_instr,      32'hA5A5_0010);

    // redirect with 2 queued and 1 in flight
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ifa.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("rd.count2", 32'(ifa.dbg_count), 32'h2);
    ifa.redirect_valid = 1'b1;
    ifa.redirect_pc    = 32'h0000_0103;
    #1;
    chk("rd.noreq", 32'(ifa.imem_req), 32'h0);
    tick();
    ifa.redirect_valid = 1'b0;
    ifa.out_ready      = 1'b1;
    #1;
    chk("rd.valid0",  32'(ifa.out_valid), 32'h0);
    chk("rd.count0",  32'(ifa.dbg_count), 32'h0);
    chk("rd.req",     32'(ifa.imem_req),  32'h1);
    chk("rd.addr100", ifa.imem_addr,      32'h100);
    tick();
    chk("rd.valid1",  32'(ifa.out_valid), 32'h0);
    chk("rd.addr104", ifa.imem_addr,      32'h104);
    tick();
    chk("rd.valid2",  32'(ifa.out_valid), 32'h1);
    chk("rd.pc100",   ifa.out_pc,         32'h100);
    chk("rd.ins100",  ifa.out_instr,      32'hA5A5_0100);

    // redirect + pop + arriving response in one cycle, then back-to-back redirects
    ifa.redirect_valid = 1'b1;
    ifa.redirect_pc    = 32'h0000_0200;
    #1;
    chk("rr.noreq0", 32'(ifa.imem_req), 32'h0);
    tick();
    ifa.redirect_pc = 32'h0000_0300;
    #1;
    chk("rr.count0", 32'(ifa.dbg_count), 32'h0);
    chk("rr.valid0", 32'(ifa.out_valid), 32'h0);
    chk("rr.noreq1", 32'(ifa.imem_req),  32'h0);
    tick();
    ifa.redirect_valid = 1'b0;
    #1;
    chk("rr.addr300", ifa.imem_addr,      32'h300);
    chk("rr.req",     32'(ifa.imem_req),  32'h1);
    chk("rr.valid1",  32'(ifa.out_valid), 32'h0);
    chk("rr.count1",  32'(ifa.dbg_count), 32'h0);
    tick();
    chk("rr.valid2",  32'(ifa.out_valid), 32'h0);
    tick();
    chk("rr.pc300",   ifa.out_pc,         32'h300);
    chk("rr.ins300",  ifa.out_instr,      32'hA5A5_0300);

    // reset mid-stream with a request in flight
    chk("mr.req_pre", 32'(ifa.imem_req), 32'h1);
    rst = 1'b1;
    tick();
    chk_reset_a("mr");
    rst = 1'b0;
    tick();
    chk("mr.valid1", 32'(ifa.out_valid), 32'h0);
    chk("mr.count1", 32'(ifa.dbg_count), 32'h0);
    chk("mr.req",    32'(ifa.imem_req),  32'h1);
    chk("mr.addr0",  ifa.imem_addr,      32'h0);
    tick();
    chk("mr.valid2", 32'(ifa.out_valid), 32'h0);
    tick();
    chk("mr.valid3", 32'(ifa.out_valid), 32'h1);
    chk("mr.pc0",    ifa.out_pc,         32'h0);
    chk("mr.ins0",   ifa.out_instr,      32'hA5A5_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
